// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: EXE_CMD codes, mul/div FSM states
// and operation selects, and the default datapath width.
package exe_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] CMD_ADD   = 4'd0;
    localparam logic [3:0] CMD_SUB   = 4'd1;
    localparam logic [3:0] CMD_AND   = 4'd2;
    localparam logic [3:0] CMD_OR    = 4'd3;
    localparam logic [3:0] CMD_NOR   = 4'd4;
    localparam logic [3:0] CMD_XOR   = 4'd5;
    localparam logic [3:0] CMD_SLL   = 4'd6;
    localparam logic [3:0] CMD_SRA   = 4'd7;
    localparam logic [3:0] CMD_SRL   = 4'd8;
    localparam logic [3:0] CMD_MULTU = 4'd9;
    localparam logic [3:0] CMD_DIVU  = 4'd10;
    localparam logic [3:0] CMD_MFHI  = 4'd11;
    localparam logic [3:0] CMD_MFLO  = 4'd12;
    localparam logic [3:0] CMD_MULT  = 4'd13;
    localparam logic [3:0] CMD_DIV   = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULU = 2'b00,
        MD_DIVU = 2'b01,
        MD_MUL  = 2'b10,
        MD_DIV  = 2'b11
    } md_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide into HI/LO: one bit per cycle, ITER cycles per op.
// state   | meaning
// IDLE    | waiting for start, HI/LO hold last result
// MUL     | shift-add multiply in progress
// DIV     | restoring divide in progress
module muldiv_unit
    import exe_pkg::*;
#(
    parameter int WIDTH = exe_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic             sa, sb;
    logic [WIDTH-1:0] ua, ub;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] mul_cat;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        // signed ops run on magnitudes; sign is restored on the final write
        sa       = (op == MD_MUL || op == MD_DIV) && a[WIDTH-1];
        sb       = (op == MD_MUL || op == MD_DIV) && b[WIDTH-1];
        ua       = sa ? -a : a;
        ub       = sb ? -b : b;
        mul_sum  = acc + (shr[0] ? {1'b0, dvs} : '0);
        mul_cat  = {mul_sum, shr} >> 1;
        prod     = neg_q ? -mul_cat[2*WIDTH-1:0] : mul_cat[2*WIDTH-1:0];
        div_diff = {1'b0, acc[WIDTH-1:0], shr[WIDTH-1]} - {2'b00, dvs};
        div_ok   = ~div_diff[WIDTH+1];
        rem_n    = div_ok ? div_diff[WIDTH:0] : {acc[WIDTH-1:0], shr[WIDTH-1]};
        quo_n    = {shr[WIDTH-2:0], div_ok};
        q_fix    = neg_q ? -quo_n : quo_n;
        r_fix    = neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            shr   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        acc <= '0;
                        shr <= ua;
                        dvs <= ub;
                        if (op == MD_DIVU || op == MD_DIV) begin
                            state <= ST_DIV;
                            // zero divisor keeps the all-ones quotient unsigned
                            neg_q <= (sa ^ sb) && (b != '0);
                            neg_r <= sa;
                        end else begin
                            state <= ST_MUL;
                            neg_q <= sa ^ sb;
                            neg_r <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= mul_cat[2*WIDTH:WIDTH];
                    shr <= mul_cat[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER-1)) begin
                        {hi, lo} <= prod;
                        state    <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    acc <= rem_n;
                    shr <= quo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER-1)) begin
                        lo    <= q_fix;
                        hi    <= r_fix;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, iterative mul/div, EXE/MEM registers.
// Define SIGNED_MULDIV_EN to turn codes 13/14 into signed MULT/DIV.
module exe_stage
    import exe_pkg::*;
#(
    parameter int WIDTH = exe_pkg::WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] Val1,
    input  logic [WIDTH-1:0] Val2,
    input  logic [WIDTH-1:0] ST_val_in,
    input  logic             MEM_R_EN_in,
    input  logic             MEM_W_EN_in,
    input  logic             WB_EN_in,
    input  logic [4:0]       Dest_in,
    input  logic             flush,
    output logic             valid_out,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] ST_val,
    output logic             MEM_R_EN,
    output logic             MEM_W_EN,
    output logic             WB_EN,
    output logic [4:0]       Dest,
    output logic             stall
);

    localparam int SW = $clog2(WIDTH);

    logic             is_md;
    md_op_t           md_op;
    logic             md_busy;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] alu;
    logic [SW-1:0]    shamt;

    assign shamt = Val2[SW-1:0];
    assign stall = md_busy;

    always_comb begin
        is_md = 1'b0;
        md_op = MD_MULU;
        case (EXE_CMD)
            CMD_MULTU: is_md = 1'b1;
            CMD_DIVU: begin
                is_md = 1'b1;
                md_op = MD_DIVU;
            end
`ifdef SIGNED_MULDIV_EN
            CMD_MULT: begin
                is_md = 1'b1;
                md_op = MD_MUL;
            end
            CMD_DIV: begin
                is_md = 1'b1;
                md_op = MD_DIV;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        alu = '0;
        case (EXE_CMD)
            CMD_ADD:  alu = Val1 + Val2;
            CMD_SUB:  alu = Val1 - Val2;
            CMD_AND:  alu = Val1 & Val2;
            CMD_OR:   alu = Val1 | Val2;
            CMD_NOR:  alu = ~(Val1 | Val2);
            CMD_XOR:  alu = Val1 ^ Val2;
            CMD_SLL:  alu = Val1 << shamt;
            CMD_SRA:  alu = WIDTH'($signed(Val1) >>> shamt);
            CMD_SRL:  alu = Val1 >> shamt;
            CMD_MFHI: alu = hi;
            CMD_MFLO: alu = lo;
            default:  alu = '0;
        endcase
    end

    muldiv_unit #(.WIDTH(WIDTH), .ITER(ITER)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (valid_in && !md_busy && !flush && is_md),
        .op    (md_op),
        .a     (Val1),
        .b     (Val2),
        .flush (flush),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush || md_busy || !valid_in) begin
            valid_out  <= 1'b0;
            ALU_result <= '0;
            ST_val     <= '0;
            MEM_R_EN   <= 1'b0;
            MEM_W_EN   <= 1'b0;
            WB_EN      <= 1'b0;
            Dest       <= '0;
        end else begin
            valid_out <= 1'b1;
            ST_val    <= ST_val_in;
            Dest      <= Dest_in;
            // a mul/div leaves the stage as a no-op; its result is read via MFHI/MFLO
            if (is_md) begin
                ALU_result <= '0;
                MEM_R_EN   <= 1'b0;
                MEM_W_EN   <= 1'b0;
                WB_EN      <= 1'b0;
            end else begin
                ALU_result <= alu;
                MEM_R_EN   <= MEM_R_EN_in;
                MEM_W_EN   <= MEM_W_EN_in;
                WB_EN      <= WB_EN_in;
            end
        end
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly upstream of the MEM stage.
- Performs single-cycle ALU ops plus iterative 32-cycle unsigned multiply/divide into HI/LO.
- Registers results and control into the EXE/MEM boundary: ALU_result, ST_val, MEM_R_EN, MEM_W_EN.
- Asserts stall to freeze ID and IF while a mul/div is in progress.

Parameters:
- WIDTH, 32, datapath width.
- ITER, 32, mul/div iterations; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid_in  in  1  instruction present from ID.
- EXE_CMD  in  4  operation code.
- Val1  in  32  operand A (rs).
- Val2  in  32  operand B (rt/imm; shift amount is Val2[4:0]).
- ST_val_in  in  32  store data.
- MEM_R_EN_in  in  1  load.
- MEM_W_EN_in  in  1  store.
- WB_EN_in  in  1  register writeback.
- Dest_in  in  5  destination register.
- flush  in  1  kill current and in-flight operation.
- valid_out  out  1  output slot holds an instruction.
- ALU_result  out  32  result or address to MEM.
- ST_val  out  32  store data to MEM.
- MEM_R_EN  out  1  registered control.
- MEM_W_EN  out  1  registered control.
- WB_EN  out  1  registered control.
- Dest  out  5  registered control.
- stall  out  1  upstream must hold its instruction.

Behaviour:
- Reset: sync active-low; rst_n=0 at an edge clears every output register and HI/LO to 0, counter to 0, FSM to IDLE. stall=0 during and after reset. rst_n has priority over flush.
- EXE_CMD codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR (all mod 2^32, no overflow trap).
  - 6 SLL, 7 SRA, 8 SRL.
  - 9 MULTU, 10 DIVU, 11 MFHI, 12 MFLO.
  - 13-15 undefined: ALU_result=0, controls pass through.
- ALU ops: 1-cycle latency; result and controls registered at the edge where valid_in=1 and stall=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE + valid_in + cmd 9/10: latch operands, counter=0, go to MUL/DIV.
  - The mul/div instruction itself is emitted next edge with valid_out=1, WB_EN=0, MEM_R_EN=0, MEM_W_EN=0, ALU_result=0.
- MUL: shift-add, one bit per cycle. DIV: restoring, one quotient bit per cycle.
  - At counter==ITER-1: write {HI,LO}=product, or LO=quotient and HI=remainder; return to IDLE.
- stall=1 combinationally whenever state is MUL or DIV: exactly ITER cycles, starting the cycle after acceptance.
  - While stalled: inputs ignored, valid_out=0 (bubbles).
- MFHI/MFLO issued immediately after a mul/div see the new HI/LO, because stall holds them until the write completes.
- Divide by zero: LO=0xFFFFFFFF, HI=Val1; still takes ITER cycles.
- flush=1 at an edge:
  - valid_out=0 and all control outputs 0 next cycle.
  - Any MUL/DIV aborts to IDLE; HI/LO unchanged; stall deasserts next cycle.
  - The instruction presented that cycle is discarded.
- valid_in=0: valid_out=0 and controls cleared next cycle.

Optional Feature:
- Macro: SIGNED_MULDIV_EN.
- Defined:
  - Codes 13 MULT and 14 DIV become signed. Operands are converted to magnitude, the same unsigned core runs, and results are sign-corrected.
  - Remainder takes the dividend's sign.
  - Divide by zero behaves as for unsigned.
  - Latency identical.
- Undefined: codes 13/14 behave as undefined ops (result 0, no stall).

Decomposition:
- Shared package exe_pkg: EXE_CMD code constants, FSM state encoding, WIDTH.
- Sub-module muldiv_unit: FSM, counter, HI/LO datapath. Ports: start, op, a, b, flush, busy, hi, lo.
- ALU combinational logic and output registers stay in exe_stage.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs -> all outputs 0, stall=0; MFHI afterwards -> ALU_result=0.
- ALU: SUB 5,7 -> 0xFFFFFFFE next cycle; SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000.
- MULTU 0x00010000 x 0x00010000, then MFHI, MFLO -> stall high exactly 32 cycles; MFHI=0x00000001, MFLO=0x00000000.
- DIVU 100/7 -> LO=14, HI=2. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- Flush at stall cycle 10 of a MULTU (HI/LO preloaded 0xA/0xB) -> stall=0 next cycle; MFHI=0xA, MFLO=0xB.
- SIGNED_MULDIV_EN: MULT -3 x 4 -> HI=0xFFFFFFFF, LO=0xFFFFFFF4; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
